// File: rtl/dpram_lsu_port.sv
// -----------------------------------------------------------------------------
// dpram_lsu_port
//
// Initiator for port B of the data RAM: the RAM has byte write strobes and a
// 1-cycle synchronous read. A byte-addressed load/store request arriving on a
// valid/ready handshake is turned into RAM enable/strobe/data signals. Sub-word
// store data is replicated onto the byte lanes. Sub-word load data is pulled
// from its lane and zero- or sign-extended. Only one transaction is in flight.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only while idle)
//   req_we                   1 = store, 0 = load
//   req_addr                 byte address
//   req_size                 0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_sext                 sign-extend a byte/half load result
//   req_wdata                store data, right-aligned
//   rsp_valid / rsp_ready    response handshake, response held until taken
//   rsp_rdata                load data, right-aligned and extended (0 otherwise)
//   rsp_err                  misaligned, illegal size or out-of-range address
//   ram_en/we/wem/addr/din   RAM port B controls, driven only in the accept cycle
//   ram_dout                 RAM read data, valid the cycle after ram_en
// -----------------------------------------------------------------------------
module dpram_lsu_port #(
    parameter  int RAM_DEPTH = 2048,
    // Bits needed to hold RAM_DEPTH-1
    localparam int AW = (RAM_DEPTH <= 2) ? 1 : $clog2(RAM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [1:0]    req_size,
    input  logic          req_sext,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          ram_en,
    output logic          ram_we,
    output logic [3:0]    ram_wem,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t      state_reg, state_next;

    // Load context, captured at accept and used when ram_dout arrives
    logic [1:0]  lane_reg;
    logic [1:0]  size_reg;
    logic        sext_reg;

    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        accept;
    logic        size_err;
    logic        align_err;
    logic        range_err;
    logic        req_err;
    logic [3:0]  lane_wem;
    logic [31:0] lane_din;
    logic [7:0]  dout_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign req_ready = (state_reg == IDLE);
    assign accept    = req_valid & req_ready;

    assign size_err  = (req_size == 2'd3);
    assign align_err = ((req_size == 2'd1) & req_addr[0]) |
                       ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));
    // Anything above the last RAM word is out of range
    assign range_err = |req_addr[31:AW+2];
    assign req_err   = size_err | align_err | range_err;

    // Store lane placement: data is replicated across all lanes, so only the
    // strobes depend on the low address bits.
    always_comb begin
        lane_wem = 4'b0000;
        lane_din = req_wdata;
        case (req_size)
            2'd0: begin
                lane_din = {4{req_wdata[7:0]}};
                lane_wem = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                lane_din = {2{req_wdata[15:0]}};
                lane_wem = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                lane_din = req_wdata;
                lane_wem = 4'b1111;
            end
            default: begin
                lane_din = req_wdata;
                lane_wem = 4'b0000;
            end
        endcase
    end

    // RAM port: purely combinational from the request, so the RAM sees the
    // access on the same edge that accepts the request. Errors never reach it.
    assign ram_en   = accept & ~req_err;
    assign ram_we   = ram_en & req_we;
    assign ram_wem  = ram_we ? lane_wem : 4'b0000;
    assign ram_addr = ram_en ? req_addr[AW+1:2] : '0;
    assign ram_din  = ram_we ? lane_din : 32'd0;

    // ------------------------------------------------------------------
    // Load extract
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_dout_lane
        assign dout_byte[gi] = ram_dout[8*gi +: 8];
    end

    assign byte_sel = dout_byte[lane_reg];
    assign half_sel = lane_reg[1] ? ram_dout[31:16] : ram_dout[15:0];

    always_comb begin
        load_data = ram_dout;
        case (size_reg)
            2'd0:    load_data = {{24{sext_reg & byte_sel[7]}}, byte_sel};
            2'd1:    load_data = {{16{sext_reg & half_sel[15]}}, half_sel};
            default: load_data = ram_dout;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    // Stores and errors answer immediately; legal loads wait
                    // one cycle for the RAM read data.
                    if (req_err || req_we) begin
                        state_next = RSP;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = RSP;
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            lane_reg  <= 2'b00;
            size_reg  <= 2'b00;
            sext_reg  <= 1'b0;
            rdata_reg <= 32'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                // Stores and errors respond with zero data
                rdata_reg <= 32'd0;
                err_reg   <= req_err;
                if (!req_err && !req_we) begin
                    lane_reg <= req_addr[1:0];
                    size_reg <= req_size;
                    sext_reg <= req_sext;
                end
            end
            if (state_reg == RD) begin
                rdata_reg <= load_data;
            end
        end
    end

    // Response registers only change in IDLE/RD, so they stay put through RSP
    assign rsp_valid = (state_reg == RSP);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_dpram_lsu_port.sv
module tb_dpram_lsu_port;

    localparam int RAM_DEPTH = 2048;
    localparam int AW        = 11;
    localparam int BYTES     = RAM_DEPTH * 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic          req_sext;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          ram_en;
    logic          ram_we;
    logic [3:0]    ram_wem;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    dpram_lsu_port #(.RAM_DEPTH(RAM_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_size  (req_size),
        .req_sext  (req_sext),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_wem   (ram_wem),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [7:0]  model_mem [0:BYTES-1];
    logic [31:0] ram_array [0:RAM_DEPTH-1];
    int          rdy_mode = 2;   // 0 random, 1 held low, 2 held high

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Behavioural RAM port B: byte strobes, read-first, 1-cycle read latency
    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_en) begin
            w = ram_array[ram_addr];
            for (int b = 0; b < 4; b++) begin
                if (ram_we && ram_wem[b]) w[8*b +: 8] = ram_din[8*b +: 8];
            end
            ram_array[ram_addr] <= w;
            ram_dout <= ram_array[ram_addr];
        end
    end

    // Reference model over a flat byte array
    function automatic void model_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                     input logic sext, input logic [31:0] wdata,
                                     output logic err, output logic [31:0] rdata,
                                     output logic [3:0] wem, output logic [31:0] din);
        int n;
        int a;
        logic [31:0] val;
        n     = 1 << size;
        err   = (size == 2'd3) || ((addr % n) != 0) || (addr >= BYTES);
        rdata = 32'd0;
        wem   = 4'b0000;
        din   = 32'd0;
        if (!err) begin
            a = int'(addr);
            if (we) begin
                for (int i = 0; i < n; i++) begin
                    model_mem[a + i] = wdata[8*i +: 8];
                    wem[(a % 4) + i] = 1'b1;
                end
                for (int l = 0; l < 4; l++) din[8*l +: 8] = wdata[8*(l % n) +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val[8*i +: 8] = model_mem[a + i];
                if (sext && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                rdata = val;
            end
        end
    endfunction

    // rsp_ready driver
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 3) != 0);
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops expected responses on each handshake, checks stability
    initial begin
        logic        hold_pending;
        logic [31:0] held_rdata;
        logic        held_err;
        rsp_t        e;
        hold_pending = 1'b0;
        held_rdata   = 32'd0;
        held_err     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else if (rsp_valid) begin
                check("req_ready_while_busy", {31'd0, req_ready}, 32'd0);
                if (hold_pending) begin
                    check("rsp_rdata_stable", rsp_rdata, held_rdata);
                    check("rsp_err_stable", {31'd0, rsp_err}, {31'd0, held_err});
                end
                if (rsp_ready) begin
                    hold_pending = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                        $display("rsp rdata=0x%08h err=%0d", rsp_rdata, rsp_err);
                    end
                end else begin
                    hold_pending = 1'b1;
                    held_rdata   = rsp_rdata;
                    held_err     = rsp_err;
                end
            end else if (hold_pending) begin
                check("rsp_valid_dropped", 32'd0, 32'd1);
                hold_pending = 1'b0;
            end
        end
    end

    // Issue one request, check the RAM port at the accept cycle and latency
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic sext, input logic [31:0] wdata);
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  wem;
        logic [31:0] din;
        int          cyc;
        rsp_t        e;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_sext  = sext;
        req_wdata = wdata;
        cyc = 0;
        @(negedge clk);
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        model_op(we, addr, size, sext, wdata, err, rdata, wem, din);
        check("ram_en", {31'd0, ram_en}, {31'd0, ~err});
        check("ram_we", {31'd0, ram_we}, {31'd0, ~err & we});
        check("ram_wem", {28'd0, ram_wem}, {28'd0, wem});
        if (!err) check("ram_addr", {21'd0, ram_addr}, addr >> 2);
        if (!err && we) check("ram_din", ram_din, din);
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
        $display("req we=%0d addr=0x%08h size=%0d sext=%0d wdata=0x%08h exp_rdata=0x%08h exp_err=%0d",
                 we, addr, size, sext, wdata, rdata, err);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        if (we || err) begin
            check("store_latency", {31'd0, rsp_valid}, 32'd1);
        end else begin
            check("load_latency_c1", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
            check("load_latency_c2", {31'd0, rsp_valid}, 32'd1);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || rsp_valid) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [1:0]  s;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_size  = 2'd0;
        req_sext  = 1'b0;
        req_wdata = 32'd0;
        for (int i = 0; i < BYTES; i++) model_mem[i] = 8'd0;
        for (int i = 0; i < RAM_DEPTH; i++) ram_array[i] <= 32'd0;
        repeat (3) @(negedge clk);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: word store / load
        do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'h1122_3344);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        // 2: byte store, signed and unsigned byte load
        do_req(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_00AB);
        do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'h0);
        do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0);
        // 3: half store, word and signed half load
        do_req(1'b1, 32'h12, 2'd1, 1'b0, 32'h0000_8001);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        do_req(1'b0, 32'h12, 2'd1, 1'b1, 32'h0);
        // 4: errors never touch the RAM
        do_req(1'b1, 32'h11, 2'd1, 1'b0, 32'hDEAD_BEEF);
        do_req(1'b1, 32'h10, 2'd3, 1'b0, 32'hDEAD_BEEF);
        do_req(1'b1, BYTES, 2'd2, 1'b0, 32'hDEAD_BEEF);
        do_req(1'b0, 32'h11, 2'd1, 1'b0, 32'h0);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        drain();

        // 5: response back-pressure
        @(negedge clk);
        rdy_mode = 1;
        @(negedge clk);
        do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
        v = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_rdata", rsp_rdata, v);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        rdy_mode = 2;
        @(negedge clk);
        check("hold_release_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check("ready_after_handshake", {31'd0, req_ready}, 32'd1);
        check("valid_after_handshake", {31'd0, rsp_valid}, 32'd0);
        do_req(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFE_F00D);
        drain();

        // 6: reset during RD
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h20;
        req_size  = 2'd2;
        req_sext  = 1'b0;
        @(negedge clk);
        check("rd_reset_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rd_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rd_reset_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rd_reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("rd_reset_valid_after", {31'd0, rsp_valid}, 32'd0);
        $display("reset during RD done");

        // Randomized traffic with random back-pressure
        rdy_mode = 0;
        for (int n = 0; n < 300; n++) begin
            s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = $urandom_range(0, 127);
            if (s != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
            do_req(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
